irq_request_register_n: RTL and testbench
=========================================

Name: irq_request_register_n

Overview:
Parametrised N-channel interrupt request register for the 8259A-style PIC. It is the successor to the fixed 8-input combinational IRR. It adds:
- input synchronisation
- true edge-sense arming per channel
- level/edge mode selected by ICW1.LTIM
- a registered ack handshake towards the priority resolver
- an indexed service clear

It sits between the IR pins and the priority resolver / data bus buffer.

Parameters:
NUM_IRQ, 8, number of interrupt request channels (2..32)
IDX_W, 3, width of service-clear index; must satisfy 2**IDX_W >= NUM_IRQ

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ir_in  input  NUM_IRQ  asynchronous interrupt request pins, bit i = IRi
icw1_write  input  1  one-cycle pulse: ICW1 being written, re-initialises edge sense
ltim  input  1  ICW1 bit 3: 1 = level-triggered, 0 = edge-triggered
imr_mask  input  NUM_IRQ  interrupt mask, 1 = masked
read_priority  input  1  resolver request for a masked-request snapshot, held until ack
read_priority_ack  output  1  one-cycle ack; rised_bits valid in the same cycle
rised_bits  output  NUM_IRQ  registered snapshot of irr & ~imr_mask
reset_irr_valid  input  1  service-clear strobe from the resolver
reset_irr_index  input  IDX_W  channel to clear
read_irr  input  1  control logic requests IRR on the data bus
data_buffer  output  NUM_IRQ  registered raw IRR when read, else 0

Behaviour:
- Reset (clk edge with reset=1):
  - irr, sync stages, rised_bits, data_buffer, read_priority_ack all = 0
  - prev (edge history) = all 1s
  - FSM = IDLE
- Synchroniser: two-flop per bit, ir_in -> s1 -> s2.
- Edge mode (ltim=0):
  - bit i is set when s2[i]=1 and prev[i]=0
  - prev <= s2 every cycle
  - a set bit stays set until serviced; re-trigger requires IRi to go low and then high again.
- Level mode (ltim=1):
  - irr[i] <= s2[i] every cycle, unless cleared by reset_irr in that cycle
  - a serviced bit reappears the next cycle if the level is still high.
- Latency: ir_in rising before edge k -> irr bit set after edge k+2.
- icw1_write:
  - clears irr and sets prev = all 1s (a pin already high gives no edge)
  - takes priority over set and clear in the same cycle.
- Service clear:
  - reset_irr_valid=1 with index < NUM_IRQ clears irr[index].
  - index >= NUM_IRQ is ignored, with no side effects.
  - A new edge on the same channel in the same cycle wins: the bit stays set.
- Handshake FSM (IDLE, ACK, WAIT_LOW):
  - IDLE: read_priority=1 -> ACK; rised_bits <= irr & ~imr_mask, using the current register value and mask.
  - ACK: read_priority_ack=1 for exactly this cycle -> WAIT_LOW.
  - WAIT_LOW: stays until read_priority=0 -> IDLE. Holding the request yields exactly one ack.
  - rised_bits holds its value between snapshots.
  - Mask changes after a snapshot do not alter rised_bits.
- data_buffer <= read_irr ? irr : 0, one-cycle latency; shows unmasked IRR.
- reset mid-handshake: FSM returns to IDLE and ack drops at that edge.
- ltim change without icw1_write: takes effect next cycle; irr is not cleared.

Optional Feature:
IRQ_GLITCH_FILTER_EN:
- Defined: adds a third sync stage s3 and a filtered value f.
  - f[i] updates to s2[i] only when s2[i]==s3[i]; otherwise it holds.
  - Edge and level logic use f instead of s2.
  - Pulses of one clock or less are rejected.
  - Latency becomes k+3.
  - Reset sets s3=0, f=0.
- Undefined: no filter; latency k+2 as above.

Test Plan:
1. Edge mode, NUM_IRQ=8, ltim=0: ir_in=8'h00 -> 8'h04 at edge 10, held high → irr=8'h04 after edge 12. Snapshot with imr_mask=8'h00 returns rised_bits=8'h04 with a single ack.
2. Edge re-arm: after clearing IR2 via reset_irr_index=2 while the pin stays high → irr bit 2 stays 0. Drop the pin for 3 cycles, then raise it → bit 2 set again 3 cycles after the rise.
3. Level mode, ltim=1: ir_in=8'h81 held; clear index 7 → irr bit 7 is 0 for one cycle, then returns to 8'h81. Release IR0 → irr=8'h80 two cycles later.
4. Masking/handshake: irr=8'h6A, imr_mask=8'hB4, read_priority held 5 cycles → rised_bits=8'h4A and exactly one ack pulse. Ack pulses again only after read_priority goes low and high.
5. Simultaneous events:
   - new IR3 edge and reset_irr_index=3 in the same cycle → bit 3 remains 1.
   - icw1_write with a pending IR5 → irr=0, and IR5 held high gives no new set.
   - reset_irr_index=7 when NUM_IRQ=6 → no change.
6. read_irr=1 with irr=8'h11 → data_buffer=8'h11 next cycle, 0 after read_irr drops. With IRQ_GLITCH_FILTER_EN, a 1-cycle pulse on IR1 → irr unchanged.

Source files
------------

// File: rtl/irq_request_register_n_if.sv
// ---------------------------------------------------------------------------
// irq_request_register_n_if
//   Bus between the interrupt request register and the priority resolver /
//   control logic of an 8259A-style PIC.
//
//   read_priority      resolver -> IRR : snapshot request, held until ack
//   read_priority_ack  IRR -> resolver : one-cycle ack, rised_bits valid with it
//   rised_bits         IRR -> resolver : registered snapshot of irr & ~imr
//   reset_irr_valid    resolver -> IRR : service-clear strobe
//   reset_irr_index    resolver -> IRR : channel to clear
//   read_irr           control  -> IRR : put raw IRR on the data bus
//   data_buffer        IRR -> control  : registered raw IRR when read, else 0
//
//   master = resolver/control side, slave = request register side.
// ---------------------------------------------------------------------------
interface irq_request_register_n_if #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
);
  logic               read_priority;
  logic               read_priority_ack;
  logic [NUM_IRQ-1:0] rised_bits;
  logic               reset_irr_valid;
  logic [IDX_W-1:0]   reset_irr_index;
  logic               read_irr;
  logic [NUM_IRQ-1:0] data_buffer;

  modport master (
    output read_priority,
    output reset_irr_valid,
    output reset_irr_index,
    output read_irr,
    input  read_priority_ack,
    input  rised_bits,
    input  data_buffer
  );

  modport slave (
    input  read_priority,
    input  reset_irr_valid,
    input  reset_irr_index,
    input  read_irr,
    output read_priority_ack,
    output rised_bits,
    output data_buffer
  );
endinterface

// File: rtl/irq_request_register_n.sv
// ---------------------------------------------------------------------------
// irq_request_register_n
//   N-channel interrupt request register for an 8259A-style PIC. Sits between
//   the IR pins and the priority resolver / data bus buffer.
//
//   Ports:
//     clk         system clock, all state on the rising edge
//     reset       synchronous active-high reset
//     ir_in       asynchronous IR pins (bit i = IRi), two-flop synchronised
//     icw1_write  one-cycle pulse: clear IRR and re-arm edge sense
//     ltim        1 = level-triggered, 0 = edge-triggered
//     imr_mask    interrupt mask (1 = masked), applied to the snapshot only
//     bus         irq_request_register_n_if.slave (handshake, clear, readback)
//
//   Optional build macro IRQ_GLITCH_FILTER_EN: adds a third sync stage and a
//   filter that only follows the synchronised pin once it has been stable for
//   two samples, rejecting pulses of one clock or less (one extra cycle of
//   request latency).
// ---------------------------------------------------------------------------
module irq_request_register_n #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_IRQ-1:0]            ir_in,
  input  logic                          icw1_write,
  input  logic                          ltim,
  input  logic [NUM_IRQ-1:0]            imr_mask,
  irq_request_register_n_if.slave       bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [NUM_IRQ-1:0] s1_q, s2_q;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] rised_q, rised_d;
  logic [NUM_IRQ-1:0] dbuf_q, dbuf_d;
  logic               ack_q, ack_d;
  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] src;
  logic [NUM_IRQ-1:0] clr;
  logic               snap_en;

`ifdef IRQ_GLITCH_FILTER_EN
  logic [NUM_IRQ-1:0] s3_q;
  logic [NUM_IRQ-1:0] f_q, f_d;

  // Follow s2 only where it agrees with its previous sample; otherwise hold.
  // The request logic uses the freshly filtered value so the filter costs
  // exactly one cycle of latency.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (s2_q[i] == s3_q[i]) f_d[i] = s2_q[i];
    end
    src = f_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_q <= '0;
      f_q  <= '0;
    end else begin
      s3_q <= s2_q;
      f_q  <= f_d;
    end
  end
`else
  always_comb src = s2_q;
`endif

  // One-hot service clear. Indices beyond NUM_IRQ-1 match no channel and so
  // are ignored without side effects.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = bus.reset_irr_valid && (bus.reset_irr_index == IDX_W'(i));
    end
  end

  // Request register. icw1_write dominates; prev is forced to all ones so a
  // pin that is already high does not look like a fresh edge. In edge mode a
  // new edge beats a clear of the same channel; in level mode the clear wins
  // for one cycle and the bit returns if the level persists.
  always_comb begin
    prev_d = src;
    if (icw1_write) begin
      irr_d  = '0;
      prev_d = '1;
    end else if (ltim) begin
      irr_d = src & ~clr;
    end else begin
      irr_d = (irr_q & ~clr) | (src & ~prev_q);
    end
  end

  // Handshake: a held request yields one ack, the next needs read_priority
  // to return low first.
  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read_priority) begin
          state_d = ACK;
          snap_en = 1'b1;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.read_priority) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d   = (state_d == ACK);
    rised_d = snap_en ? (irr_q & ~imr_mask) : rised_q;
    dbuf_d  = bus.read_irr ? irr_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '1;
      irr_q   <= '0;
      rised_q <= '0;
      dbuf_q  <= '0;
      ack_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q    <= ir_in;
      s2_q    <= s1_q;
      prev_q  <= prev_d;
      irr_q   <= irr_d;
      rised_q <= rised_d;
      dbuf_q  <= dbuf_d;
      ack_q   <= ack_d;
      state_q <= state_d;
    end
  end

  assign bus.read_priority_ack = ack_q;
  assign bus.rised_bits        = rised_q;
  assign bus.data_buffer       = dbuf_q;

endmodule

// File: tb/tb_irq_request_register_n.sv
module tb_irq_request_register_n;
  localparam int N  = 8;
  localparam int IW = 4;   // wider than needed so out-of-range clears get exercised
`ifdef IRQ_GLITCH_FILTER_EN
  localparam int EX = 1;
`else
  localparam int EX = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] ir_in;
  logic         icw1_write;
  logic         ltim;
  logic [N-1:0] imr_mask;

  irq_request_register_n_if #(.NUM_IRQ(N), .IDX_W(IW)) bus ();

  irq_request_register_n #(.NUM_IRQ(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_in      (ir_in),
    .icw1_write (icw1_write),
    .ltim       (ltim),
    .imr_mask   (imr_mask),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: pin history (pin value seen 1, 2, 3 edges ago), the
  // filtered view, the request set and the handshake bookkeeping.
  logic [N-1:0] h1, h2, h3, m_filt;
  logic [N-1:0] m_irr, m_prev, m_rised, m_dbuf;
  logic         m_ack, m_engaged;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] src, clr, irr_old;
    logic         ack_old;
    if (reset) begin
      h1 = '0; h2 = '0; h3 = '0; m_filt = '0;
      m_irr = '0; m_prev = '1; m_rised = '0; m_dbuf = '0;
      m_ack = 1'b0; m_engaged = 1'b0;
      return;
    end
`ifdef IRQ_GLITCH_FILTER_EN
    for (int i = 0; i < N; i++) if (h2[i] == h3[i]) m_filt[i] = h2[i];
    src = m_filt;
`else
    src = h2;
`endif
    clr = '0;
    if (bus.reset_irr_valid && (int'(bus.reset_irr_index) < N))
      clr = N'(1) << bus.reset_irr_index;
    irr_old = m_irr;
    ack_old = m_ack;
    m_dbuf = bus.read_irr ? irr_old : '0;
    // A request is answered once; the responder re-arms only after the
    // request has been seen low following the ack cycle.
    m_ack = bus.read_priority && !m_engaged;
    if (m_ack) m_rised = irr_old & ~imr_mask;
    m_engaged = m_ack || (m_engaged && (bus.read_priority || ack_old));
    if (icw1_write) begin
      m_irr  = '0;
      m_prev = '1;
    end else begin
      if (ltim) m_irr = src & ~clr;
      else      m_irr = (irr_old & ~clr) | (src & ~m_prev);
      m_prev = src;
    end
    h3 = h2; h2 = h1; h1 = ir_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ack",   {31'd0, bus.read_priority_ack}, {31'd0, m_ack});
    check("rised", 32'(bus.rised_bits),            32'(m_rised));
    check("dbuf",  32'(bus.data_buffer),           32'(m_dbuf));
  endtask

  task automatic idle_inputs();
    icw1_write = 0; bus.read_priority = 0; bus.reset_irr_valid = 0;
    bus.reset_irr_index = '0; bus.read_irr = 0;
  endtask

  task automatic clear_idx(input int idx);
    bus.reset_irr_valid = 1; bus.reset_irr_index = IW'(idx);
    tick();
    bus.reset_irr_valid = 0;
  endtask

  initial begin
    int ack_cnt;
    reset = 1; ir_in = '0; ltim = 0; imr_mask = '0;
    idle_inputs();
    repeat (2) tick();
    check("rst_ack",   {31'd0, bus.read_priority_ack}, 32'd0);
    check("rst_rised", 32'(bus.rised_bits), 32'd0);
    check("rst_dbuf",  32'(bus.data_buffer), 32'd0);
    reset = 0;
    repeat (4) tick();

    // 1: edge mode latency and single snapshot
    bus.read_irr = 1;
    ir_in = 8'h04;
    repeat (3 + EX) tick();
    check("t1_before", 32'(bus.data_buffer), 32'h00);
    tick();
    check("t1_irr", 32'(bus.data_buffer), 32'h04);
    bus.read_priority = 1;
    ack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.read_priority_ack) ack_cnt++;
    end
    check("t1_acks", 32'(ack_cnt), 32'd1);
    check("t1_rised", 32'(bus.rised_bits), 32'h04);
    bus.read_priority = 0;
    tick();

    // 2: clear with pin still high stays clear; re-arm after a low period
    clear_idx(2);
    repeat (4) tick();
    check("t2_cleared", 32'(bus.data_buffer), 32'h00);
    ir_in = 8'h00; repeat (3) tick();
    ir_in = 8'h04; repeat (4 + EX) tick();
    check("t2_rearm", 32'(bus.data_buffer), 32'h04);

    // 3: level mode with a clear while the level is held
    ltim = 1; ir_in = 8'h81; repeat (5) tick();
    check("t3_level", 32'(bus.data_buffer), 32'h81);
    clear_idx(7);
    tick();
    check("t3_gap", 32'(bus.data_buffer), 32'h01);
    tick();
    check("t3_back", 32'(bus.data_buffer), 32'h81);
    ir_in = 8'h80; repeat (6) tick();
    check("t3_rel", 32'(bus.data_buffer), 32'h80);

    // 4: masked snapshot, mask change afterwards, re-request
    ir_in = 8'h6A; imr_mask = 8'hB4; repeat (5) tick();
    bus.read_priority = 1;
    ack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.read_priority_ack) ack_cnt++;
    end
    check("t4_acks", 32'(ack_cnt), 32'd1);
    check("t4_rised", 32'(bus.rised_bits), 32'h4A);
    imr_mask = 8'h00; tick();
    check("t4_hold", 32'(bus.rised_bits), 32'h4A);
    bus.read_priority = 0; repeat (2) tick();
    bus.read_priority = 1; tick();
    check("t4_reack", {31'd0, bus.read_priority_ack}, 32'd1);
    bus.read_priority = 0; tick();

    // 5: edge beats clear, icw1 dominates, out-of-range index ignored
    ltim = 0; ir_in = 8'h00; icw1_write = 1; tick(); icw1_write = 0;
    repeat (3) tick();
    ir_in = 8'h08; repeat (2 + EX) tick();
    clear_idx(3);
    tick();
    check("t5_edge_wins", 32'(bus.data_buffer), 32'h08);
    ir_in = 8'h28; repeat (6) tick();
    icw1_write = 1; tick(); icw1_write = 0;
    repeat (6) tick();
    check("t5_icw1", 32'(bus.data_buffer), 32'h00);
    ir_in = 8'h00; repeat (4) tick();
    ir_in = 8'h01; repeat (6) tick();
    clear_idx(9);
    clear_idx(15);
    tick();
    check("t5_oor", 32'(bus.data_buffer), 32'h01);

    // 6: readback gating and a one-cycle pin pulse
    bus.read_irr = 0; tick();
    check("t6_off", 32'(bus.data_buffer), 32'h00);
    bus.read_irr = 1;
    ir_in = 8'h03; tick(); ir_in = 8'h01;
    repeat (6) tick();

    // reset in the middle of a handshake
    bus.read_priority = 1; tick();
    reset = 1; tick(); reset = 0;
    check("rst_mid_ack", {31'd0, bus.read_priority_ack}, 32'd0);
    bus.read_priority = 0; repeat (3) tick();

    // Randomised traffic against the reference
    for (int c = 0; c < 6000; c++) begin
      reset      = ($urandom_range(0, 399) == 0);
      icw1_write = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) ltim = ~ltim;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) ir_in[b] = ~ir_in[b];
      if ($urandom_range(0, 19) == 0) imr_mask = N'($urandom);
      if ($urandom_range(0, 3) == 0) bus.read_priority = ~bus.read_priority;
      bus.reset_irr_valid = ($urandom_range(0, 3) == 0);
      bus.reset_irr_index = IW'($urandom_range(0, 15));
      bus.read_irr        = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
